sub_serial: RTL
===============

Name: sub_serial

Overview:
Bit-serial WIDTH-bit subtractor computing d = a − b − bi, with borrow-out bo, one bit per clock, LSB first.
It is the inverse-direction counterpart to the team's ripple-carry adders and is used where area matters more than latency.
A start/busy/done handshake lets a control FSM launch an operation and pick up the registered result.
One full-subtractor cell is reused across cycles, with a borrow flip-flop in place of the borrow ripple chain.

Parameters:
WIDTH, 4, operand and result width in bits (≥2).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  operation request; sampled only when accepting (IDLE or DONE).
a  input  WIDTH  minuend; captured on start acceptance.
b  input  WIDTH  subtrahend; captured on start acceptance.
bi  input  1  borrow in; captured on start acceptance.
d  output  WIDTH  difference; registered, changes only at completion.
bo  output  1  borrow out; registered, changes only at completion.
busy  output  1  high while an operation is in progress (RUN).
done  output  1  one-cycle pulse; d/bo are valid from this cycle on.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; d=0, bo=0, busy=0, done=0; operand shift registers, borrow FF and bit counter all 0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → capture a, b, bi; load counter=0; next state RUN.
  - RUN: busy=1 for exactly WIDTH cycles. Each cycle processes bit0 of the a/b shift registers:
    - diff = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - diff is shifted into the result shift register from the MSB end.
    - a and b shift right by one.
    - Counter increments; on counter==WIDTH-1, next state DONE.
  - DONE: done=1 and busy=0 for one cycle. d and bo are loaded on the RUN→DONE edge, so they are valid in the DONE cycle.
    - start=1 in DONE → accept the new operation, go to RUN (back-to-back operation).
    - Otherwise go to IDLE.
- Latency: start sampled at edge N → busy high N+1..N+WIDTH → done high in cycle N+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- d and bo hold their last result through IDLE, RUN and later DONE until the next completion. They never show partial results.
- start while RUN is ignored: no capture, no effect on the in-flight operation.
- Operands may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH. bo=1 iff a < b + bi, treating a and b as unsigned.
- Counter width is clog2(WIDTH). Counter and shift registers never wrap during RUN.
- rst_n asserted mid-RUN: the operation is aborted, all outputs return to reset values, and no done pulse is produced.

Decomposition:
- Shared include sub_defs.vh holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as localparams. Unused code 2'd3 recovers to IDLE.
- Sub-module fs_bit is a combinational full-subtractor cell: inputs a, b, bi; outputs d, bo; implemented per the equations above. It is instantiated once in sub_serial.
- The rest stays in one module: FSM, counter, shift registers, output registers.

Test Plan:
1. WIDTH=4, a=9, b=3, bi=0, start pulse → busy for 4 cycles, done in cycle 5 after the start edge, d=6, bo=0.
2. a=3, b=9, bi=0 → d=4'hA, bo=1. Also a=0, b=0, bi=1 → d=4'hF, bo=1. Also a=15, b=15, bi=0 → d=0, bo=0.
3. Exhaustive sweep (all a, b, bi for WIDTH=4): d/bo match (a−b−bi) mod 16 and the borrow flag; exactly one done per start.
4. Start a=9, b=3; hold start=1 and change a=1 during RUN → result is still 6/0; RUN lasts exactly 4 cycles; d stays at its prior value until done.
5. Start asserted in the DONE cycle with a=5, b=7 → busy the very next cycle, done 5 cycles later with d=4'hE, bo=1. The previous result stays held until then.
6. rst_n low during the second RUN cycle → d=0, bo=0, busy=0 immediately (asynchronous); no done pulse. The next start after release completes normally.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the sizing helper for the bit counter.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter width: clog2(width), but never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sub_serial_fs_bit.sv
// Combinational full-subtractor cell: d = a - b - bi for single bits,
// with the borrow propagated to the next bit position.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock. A single
// fs_bit cell is reused every cycle; the borrow lives in a flip-flop.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cell_d, cell_bo;

  fs_bit u_fs_bit (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    // NOTE: every signal gets a hold value before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    br_d    = br_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bi;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = cell_bo;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        // Outputs are loaded only here so they never expose a partial result.
        if (cnt_q == LAST_BIT) begin
          d_d     = {cell_d, res_q[WIDTH-1:1]};
          bo_d    = cell_bo;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
